timer_irq_responder: RTL and testbench

//  Memory-mapped countdown timer. Sits on the data-memory bus as a responder to the CPU memory stage.

---
 rtl/timer_irq_responder.sv | 214 +++++++++++++++++++++
 tb/tb_timer_irq_responder.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_irq_responder.sv
// ----------------------------------------------------------------------------
// timer_irq_responder
//
// Memory-mapped countdown timer that sits on the data-memory bus as a
// responder to the CPU memory stage. Word loads return registered data one
// cycle later. One level-sensitive interrupt line goes to CP0, and CP0's
// acknowledge comes back on int_clr.
//
// Register map (addr[4:2]):
//   0 CTRL    rw  bit0 En, bits[2:1] Mode (1 = auto-reload), bit3 IM
//   1 PRESET  rw  reload value
//   2 COUNT   ro  current count
//   3 STATUS      read bit0 = pending; any write clears pending
//   4 CAPTURE ro  free-running cycle count latched on INT (TIMER_CAPTURE_EN)
//   4-7           otherwise read 0, writes ignored
//
// Optional feature macro: TIMER_CAPTURE_EN (adds CAPTURE + cycle counter).
//
// Ports:
//   clk      in   1   rising-edge clock
//   reset    in   1   asynchronous active-low reset
//   sel      in   1   chip select
//   we       in   1   1 = store, 0 = load
//   addr     in   32  byte address, only [4:2] decoded
//   wdata    in   32  store data
//   int_clr  in   1   interrupt acknowledge, clears pending
//   rdata    out  32  registered load data
//   irq      out  1   pending & IM
// ----------------------------------------------------------------------------
module timer_irq_responder #(
  parameter logic [1:0]  RELOAD_MODE_DEF = 2'd0,
  parameter logic [31:0] PRESET_DEF      = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        int_clr,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  localparam logic [2:0] A_CTRL    = 3'd0;
  localparam logic [2:0] A_PRESET  = 3'd1;
  localparam logic [2:0] A_COUNT   = 3'd2;
  localparam logic [2:0] A_STATUS  = 3'd3;
  localparam logic [2:0] A_CAPTURE = 3'd4;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_en;
  logic [1:0]  r_mode;
  logic        r_im;
  logic [31:0] r_preset;
  logic [31:0] r_count;
  logic        r_pending;
  logic [31:0] r_rdata;

  logic        w_load_count;
  logic        w_dec_count;
  logic        w_set_pending;
  logic        w_clr_en;
  logic [31:0] w_rd_mux;
  logic [2:0]  w_idx;
  logic        w_wr;
  logic        w_rd;
  logic        w_unused_addr;

  assign w_idx         = addr[4:2];
  assign w_wr          = sel & we;
  assign w_rd          = sel & ~we;
  assign w_unused_addr = ^{addr[31:5], addr[1:0]};

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  // NOTE: every clocked block uses non-blocking (<=) assignments so all
  // registers sample their inputs from the same pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // --------------------------------------------------------------------------
  // FSM next state and datapath controls
  // --------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_load_count  = 1'b0;
    w_dec_count   = 1'b0;
    w_set_pending = 1'b0;
    w_clr_en      = 1'b0;
    unique case (r_state)
      ST_IDLE: if (r_en) w_state_nxt = ST_LOAD;
      ST_LOAD: begin
        w_load_count = 1'b1;
        w_state_nxt  = ST_CNT;
      end
      ST_CNT: begin
        if (!r_en) begin
          w_state_nxt = ST_IDLE;
        end else if (r_count == 32'd0) begin
          // Pending is raised on entry to INT so irq is visible during the
          // INT cycle itself; it is re-asserted while in INT so that an
          // acknowledge landing on either of these edges loses to the set.
          w_state_nxt   = ST_INT;
          w_set_pending = 1'b1;
        end else begin
          w_dec_count = 1'b1;
        end
      end
      ST_INT: begin
        w_set_pending = 1'b1;
        if (r_mode == 2'd1) begin
          w_state_nxt = ST_LOAD;
        end else begin
          w_clr_en    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // CTRL / PRESET: a CPU write to CTRL overrides the one-shot En clear
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_en     <= 1'b0;
      r_mode   <= RELOAD_MODE_DEF;
      r_im     <= 1'b0;
      r_preset <= PRESET_DEF;
    end else begin
      if (w_wr && w_idx == A_CTRL) begin
        {r_im, r_mode, r_en} <= wdata[3:0];
      end else if (w_clr_en) begin
        r_en <= 1'b0;
      end
      // PRESET only reaches COUNT in LOAD, so a mid-count write waits a run.
      if (w_wr && w_idx == A_PRESET) r_preset <= wdata;
    end
  end

  // --------------------------------------------------------------------------
  // COUNT and pending
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count   <= 32'd0;
      r_pending <= 1'b0;
    end else begin
      if (w_load_count)     r_count <= r_preset;
      else if (w_dec_count) r_count <= r_count - 32'd1;

      if (w_set_pending)                              r_pending <= 1'b1;
      else if (int_clr || (w_wr && w_idx == A_STATUS)) r_pending <= 1'b0;
    end
  end

`ifdef TIMER_CAPTURE_EN
  logic [31:0] r_cycle;
  logic [31:0] r_capture;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cycle   <= 32'd0;
      r_capture <= 32'd0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      if (r_state == ST_INT) r_capture <= r_cycle;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Read mux and registered read data (old value on same-cycle write)
  // --------------------------------------------------------------------------
  always_comb begin
    w_rd_mux = 32'd0;
    case (w_idx)
      A_CTRL:    w_rd_mux = {28'd0, r_im, r_mode, r_en};
      A_PRESET:  w_rd_mux = r_preset;
      A_COUNT:   w_rd_mux = r_count;
      A_STATUS:  w_rd_mux = {31'd0, r_pending};
`ifdef TIMER_CAPTURE_EN
      A_CAPTURE: w_rd_mux = r_capture;
`else
      A_CAPTURE: w_rd_mux = 32'd0;
`endif
      default:   w_rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    r_rdata <= 32'd0;
    else if (w_rd) r_rdata <= w_rd_mux;
  end

  assign rdata = r_rdata;
  assign irq   = r_pending & r_im;

endmodule

// File: tb/tb_timer_irq_responder.sv
// ----------------------------------------------------------------------------
// tb_timer_irq_responder
//
// Self-checking bench for timer_irq_responder. A table of register-access
// vectors covers reset values, read/write behaviour and decode; hand-written
// sequences cover the timer timing and collision corner cases. Expected load
// data is queued when a load is issued and compared when rdata is produced.
// ----------------------------------------------------------------------------
module tb_timer_irq_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        int_clr;
  logic [31:0] rdata;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[$];

  always #5 clk = ~clk;

  timer_irq_responder #(
    .RELOAD_MODE_DEF(2'd0),
    .PRESET_DEF     (32'd0)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .sel    (sel),
    .we     (we),
    .addr   (addr),
    .wdata  (wdata),
    .int_clr(int_clr),
    .rdata  (rdata),
    .irq    (irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_irq(input string name, input logic exp);
    check(name, {31'd0, irq}, {31'd0, exp});
  endtask

  // Advance n rising edges; return 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    sel   = 1'b1;
    we    = 1'b1;
    addr  = a;
    wdata = d;
    tick(1);
    sel   = 1'b0;
    we    = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [31:0] e, input string name);
    exp_t x;
    x.name = name;
    x.val  = e;
    exp_q.push_back(x);
    sel  = 1'b1;
    we   = 1'b0;
    addr = a;
    tick(1);
    sel  = 1'b0;
    x = exp_q.pop_front();
    check(x.name, rdata, x.val);
  endtask

  // Disable, let the FSM drain to IDLE, then drop any pending interrupt.
  task automatic stop_timer();
    bus_write(32'h0, 32'h0);
    tick(4);
    bus_write(32'hC, 32'h0);
  endtask

  task automatic add_vec(input string name, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] e);
    vec_t v;
    v.name  = name;
    v.we    = w;
    v.addr  = a;
    v.wdata = d;
    v.exp   = e;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    add_vec("reset_ctrl",        1'b0, 32'h00, 32'h0,        32'h0);
    add_vec("reset_preset",      1'b0, 32'h04, 32'h0,        32'h0);
    add_vec("reset_count",       1'b0, 32'h08, 32'h0,        32'h0);
    add_vec("reset_status",      1'b0, 32'h0C, 32'h0,        32'h0);
    add_vec("",                  1'b1, 32'h04, 32'hDEADBEEF, 32'h0);
    add_vec("preset_readback",   1'b0, 32'h04, 32'h0,        32'hDEADBEEF);
    add_vec("addr_low_ignored",  1'b0, 32'h07, 32'h0,        32'hDEADBEEF);
    add_vec("",                  1'b1, 32'h08, 32'h1234,     32'h0);
    add_vec("count_write_ignored", 1'b0, 32'h08, 32'h0,      32'h0);
    add_vec("",                  1'b1, 32'h00, 32'hFFFFFFF6, 32'h0);
    add_vec("ctrl_upper_bits_zero", 1'b0, 32'h00, 32'h0,     32'h6);
    add_vec("",                  1'b1, 32'h00, 32'h0,        32'h0);
    add_vec("",                  1'b1, 32'h14, 32'hFFFFFFFF, 32'h0);
    add_vec("offset4_zero",      1'b0, 32'h10, 32'h0,        32'h0);
    add_vec("offset5_zero",      1'b0, 32'h14, 32'h0,        32'h0);
    add_vec("offset7_zero",      1'b0, 32'h1C, 32'h0,        32'h0);

    reset   = 1'b0;
    sel     = 1'b0;
    we      = 1'b0;
    addr    = 32'h0;
    wdata   = 32'h0;
    int_clr = 1'b0;
    tick(2);
    #2 reset = 1'b1;
    tick(1);
    check("reset_rdata", rdata, 32'h0);
    check_irq("reset_irq", 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].we) bus_write(vecs[i].addr, vecs[i].wdata);
      else            bus_read(vecs[i].addr, vecs[i].exp, vecs[i].name);
    end

    // One-shot, PRESET=5: INT entered 8 edges after the CTRL write edge.
    bus_write(32'h4, 32'd5);
    bus_write(32'h0, 32'h9);
    tick(7);
    check_irq("oneshot_irq_before", 1'b0);
    tick(1);
    check_irq("oneshot_irq_rise", 1'b1);
    tick(1);
    bus_read(32'h0, 32'h8, "oneshot_en_cleared");
    bus_read(32'h8, 32'h0, "oneshot_count_zero");
    tick(3);
    bus_read(32'h8, 32'h0, "oneshot_count_stays");
    check_irq("oneshot_irq_held", 1'b1);
    bus_write(32'hC, 32'h0);
    check_irq("status_write_clears", 1'b0);

    // Read latency at COUNT=7, then masked interrupt (IM=0).
    bus_write(32'h4, 32'd10);
    bus_write(32'h0, 32'h1);
    tick(5);
    bus_read(32'h8, 32'd7, "read_latency_count7");
    tick(7);
    check_irq("masked_irq_low", 1'b0);
    bus_read(32'hC, 32'h1, "masked_status_pending");
    bus_read(32'h0, 32'h0, "masked_en_cleared");
    bus_write(32'hC, 32'h0);

    // Disable mid-count freezes COUNT; re-enable restarts from PRESET.
    bus_write(32'h4, 32'd20);
    bus_write(32'h0, 32'h1);
    tick(4);
    bus_write(32'h0, 32'h0);
    tick(2);
    bus_read(32'h8, 32'd17, "disable_count_frozen");
    tick(3);
    bus_read(32'h8, 32'd17, "disable_count_still_frozen");
    bus_write(32'h0, 32'h1);
    bus_read(32'h8, 32'd17, "reenable_count_old");
    tick(1);
    bus_read(32'h8, 32'd20, "reenable_count_reloaded");
    stop_timer();

    // Auto-reload, PRESET=2: period 5, int_clr on INT loses, later wins.
    bus_write(32'h4, 32'd2);
    bus_write(32'h0, 32'hB);
    tick(4);
    check_irq("auto_before_first", 1'b0);
    tick(1);
    check_irq("auto_first_int", 1'b1);
    int_clr = 1'b1;
    tick(1);
    check_irq("int_clr_on_int_set_wins", 1'b1);
    tick(1);
    int_clr = 1'b0;
    check_irq("int_clr_drops_irq", 1'b0);
    tick(2);
    check_irq("auto_gap", 1'b0);
    tick(1);
    check_irq("auto_second_int", 1'b1);
    tick(2);
    int_clr = 1'b1;
    tick(1);
    int_clr = 1'b0;
    check_irq("auto_ack_second", 1'b0);
    tick(1);
    check_irq("auto_gap2", 1'b0);
    tick(1);
    check_irq("auto_third_int", 1'b1);
    stop_timer();

    // PRESET written while COUNT=3: current run unchanged, next LOAD uses 9.
    bus_write(32'h4, 32'd4);
    bus_write(32'h0, 32'hB);
    tick(3);
    bus_write(32'h4, 32'd9);
    tick(2);
    check_irq("preset_coll_before", 1'b0);
    tick(1);
    check_irq("preset_coll_on_schedule", 1'b1);
    tick(2);
    bus_read(32'h8, 32'd9, "preset_coll_next_load");
    stop_timer();

    // PRESET=0 one-shot: INT 3 edges after enable; CTRL write on the INT
    // cycle keeps En set, so a second run follows.
    bus_write(32'h4, 32'd0);
    bus_write(32'h0, 32'h9);
    tick(2);
    check_irq("n0_before", 1'b0);
    tick(1);
    check_irq("n0_int", 1'b1);
    bus_write(32'h0, 32'h9);
    bus_read(32'h0, 32'h9, "ctrl_write_wins");
    bus_write(32'hC, 32'h0);
    check_irq("n0_cleared", 1'b0);
    tick(1);
    check_irq("n0_rerun_int", 1'b1);
    stop_timer();

    // Asynchronous reset mid-operation.
    bus_write(32'h4, 32'd1);
    bus_write(32'h0, 32'hB);
    tick(4);
    check_irq("pre_reset_irq", 1'b1);
    bus_read(32'h4, 32'd1, "pre_reset_rdata");
    #2 reset = 1'b0;
    #1;
    check("reset_async_rdata", rdata, 32'h0);
    check_irq("reset_async_irq", 1'b0);
    tick(2);
    #2 reset = 1'b1;
    tick(1);
    bus_read(32'h8, 32'h0, "post_reset_count");
    bus_read(32'h0, 32'h0, "post_reset_ctrl");
    bus_read(32'h4, 32'h0, "post_reset_preset");
    bus_read(32'hC, 32'h0, "post_reset_status");
    tick(3);
    check_irq("post_reset_idle_irq", 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
